// File: rtl/ads_sample_sched_if.sv
// ADC conversion handshake and FIFO read stream of the sample scheduler.
// The master modport is the scheduler side; the slave modport is the ADC/consumer side.
interface ads_sample_sched_if;
  logic        adc_start;
  logic        adc_done;
  logic [15:0] adc_data;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (
    output adc_start, m_data, m_valid,
    input  adc_done, adc_data, m_ready
  );

  modport slave (
    input  adc_start, m_data, m_valid,
    output adc_done, adc_data, m_ready
  );
endinterface

// File: rtl/ads_sample_sched.sv
// ADC sample scheduler: periodic or burst conversion requests with timeout,
// results buffered in a first-word-fall-through FIFO with sticky error flags.
module ads_sample_sched #(
  parameter int PERIOD_W = 16,
  parameter int FIFO_AW  = 3,
  parameter int TMO_CYC  = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cont,
  input  logic                trig,
  input  logic [PERIOD_W-1:0] period,
  input  logic [7:0]          burst_len,
  ads_sample_sched_if.master  bus,
  output logic [FIFO_AW:0]    level,
  output logic                busy,
  output logic                overflow,
  output logic                timeout,
  input  logic                clr_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t              r_state;
  logic                r_adc_start;
  logic                r_busy;
  logic                r_cont;
  logic                r_stop;
  logic [PERIOD_W-1:0] r_per_thr;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [8:0]          r_burst_tgt;
  logic [8:0]          r_samp_cnt;

  logic [15:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0]  r_wr_ptr;
  logic [FIFO_AW-1:0]  r_rd_ptr;
  logic [FIFO_AW:0]    r_level;
  logic                r_ovf;
  logic                r_tmo;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;
  logic w_ovf_set;
  logic w_tmo_hit;

  assign w_push    = (r_state == WAIT) && bus.adc_done;
  assign w_tmo_hit = (r_state == WAIT) && !bus.adc_done && (r_tmo_cnt >= TMO_W'(TMO_CYC));
  assign w_full    = (r_level == (FIFO_AW + 1)'(DEPTH));
  assign w_pop     = bus.m_valid && bus.m_ready;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  // Scheduler FSM. Counters and adc_start get a default update at the top;
  // the transition branches below override them where needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_adc_start <= 1'b0;
      r_busy      <= 1'b0;
      r_cont      <= 1'b0;
      r_stop      <= 1'b0;
      r_per_thr   <= '0;
      r_per_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_burst_tgt <= '0;
      r_samp_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments; a later assignment to the same register in this block takes precedence.
      r_adc_start <= 1'b0;
      if (r_state != IDLE && r_per_cnt != '1) r_per_cnt <= r_per_cnt + 1'b1;
      if (r_tmo_cnt != '1) r_tmo_cnt <= r_tmo_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          r_samp_cnt <= '0;
          r_stop     <= 1'b0;
          if (enable && (cont || trig)) begin
            r_cont      <= cont;
            r_per_thr   <= (period <= PERIOD_W'(1)) ? '0 : period - 1'b1;
            r_burst_tgt <= (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
            r_state     <= START;
            r_busy      <= 1'b1;
            r_adc_start <= 1'b1;
            r_per_cnt   <= '0;
            r_tmo_cnt   <= '0;
          end
        end

        START: begin
          if (!enable) r_stop <= 1'b1;
          r_state <= WAIT;
        end

        WAIT: begin
          if (!enable) r_stop <= 1'b1;
          if (bus.adc_done) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
            if (r_stop || !enable) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= GAP;
            end
          end else if (w_tmo_hit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        GAP: begin
          if (!enable || (!r_cont && r_samp_cnt >= r_burst_tgt)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_per_cnt >= r_per_thr) begin
            r_state     <= START;
            r_adc_start <= 1'b1;
            r_per_cnt   <= '0;
            r_tmo_cnt   <= '0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the sample storage is deliberately not reset; m_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.adc_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags: a set event in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_tmo_hit)    r_tmo <= 1'b1;
      else if (clr_err) r_tmo <= 1'b0;
    end
  end

  assign bus.adc_start = r_adc_start;
  assign bus.m_valid   = (r_level != '0);
  assign bus.m_data    = bus.m_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign level         = r_level;
  assign busy          = r_busy;
  assign overflow      = r_ovf;
  assign timeout       = r_tmo;

endmodule

// File: doc/ads_sample_sched.md
ADS_SAMPLE_SCHED -- requirements
Module: ads_sample_sched

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16, width of sample-period register.
REQ-002 SHALL have parameter FIFO_AW, default 3, sample FIFO address width (depth 2**FIFO_AW = 8).
REQ-003 SHALL have parameter TMO_CYC, default 1023, max cycles from adc_start to adc_done before timeout.
REQ-004 SHALL have port clk  in  1  system clock, 100 MHz.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port enable  in  1  level; scheduler runs while high.
REQ-007 SHALL have port cont  in  1  1 = continuous sampling, 0 = burst mode.
REQ-008 SHALL have port trig  in  1  one-cycle pulse; starts a burst when cont = 0.
REQ-009 SHALL have port period  in  PERIOD_W  clk cycles between successive adc_start pulses.
REQ-010 SHALL have port burst_len  in  8  samples per burst; 0 means 256.
REQ-011 SHALL have port adc_start  out  1  one-cycle conversion request to the ADC interface.
REQ-012 SHALL have port adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle.
REQ-013 SHALL have port adc_data  in  16  conversion result.
REQ-014 SHALL have ports m_data out 16, m_valid out 1, m_ready in 1: FIFO read stream.
REQ-015 SHALL have port level  out  FIFO_AW+1  current FIFO occupancy.
REQ-016 SHALL have ports busy out 1 (state != IDLE), overflow out 1 (sticky), timeout out 1 (sticky), clr_err in 1 (clears both stickies).

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT, GAP.
REQ-018 IDLE -> START when enable & (cont | trig); trig ignored outside IDLE.
REQ-019 START SHALL drive adc_start = 1 for exactly one cycle, clear period counter to 0, go to WAIT.
REQ-020 Period counter SHALL increment every cycle outside IDLE, saturating at all-ones.
REQ-021 WAIT: on adc_done, push adc_data to FIFO, increment sample count, go to GAP.
REQ-022 WAIT: if TMO_CYC cycles pass without adc_done, set timeout, go to IDLE, no push.
REQ-023 GAP -> START when period counter >= period-1; period 0 or 1 treated as 1 (restart the cycle after done).
REQ-024 Start-to-start spacing SHALL equal max(period, conversion time + 2) cycles.
REQ-025 Burst mode: after burst_len samples (0 = 256) pushed, GAP -> IDLE instead of START; sample count cleared in IDLE.
REQ-026 enable low in START/WAIT SHALL let current conversion complete (push normally), then -> IDLE; enable low in GAP -> IDLE next cycle.
REQ-027 cont, period, burst_len SHALL be sampled in IDLE on leaving it; changes mid-run ignored until next IDLE exit.
REQ-028 FIFO: m_valid = (level != 0); m_data = head entry, first-word-fall-through; pop on m_valid & m_ready.
REQ-029 Push when full SHALL drop the sample and set overflow, unless a pop occurs the same cycle, in which case push accepted, level unchanged.
REQ-030 Simultaneous push and pop when not full/empty SHALL leave level unchanged; pop on empty has no effect.
REQ-031 Pointers SHALL wrap modulo 2**FIFO_AW.
REQ-032 clr_err SHALL clear overflow/timeout next cycle; a set event in the same cycle wins.

Reset
REQ-033 rst_n low at clk edge SHALL force IDLE, FIFO empty, level 0, adc_start 0, m_valid 0, m_data 0, busy 0, overflow 0, timeout 0, counters 0, including mid-conversion; a late adc_done after reset SHALL be ignored.

Verification
REQ-034 cont=1, period=300, adc_done 150 cycles after each start, m_ready=1 -> adc_start every 300 cycles, data stream in order, no errors.
REQ-035 cont=0, burst_len=4, trig pulse -> exactly 4 adc_start pulses, 4 FIFO words, then busy=0; second trig in-burst ignored.
REQ-036 cont=1, period=10, m_ready=0, 9 conversions -> level 8, overflow=1, 9th sample dropped; clr_err -> overflow=0.
REQ-037 adc_done withheld after start -> timeout=1 at TMO_CYC cycles, state IDLE, level unchanged.
REQ-038 enable dropped in WAIT -> pending sample pushed, no further adc_start; rst_n low mid-WAIT -> all outputs 0, later adc_done not pushed.
